// File: rtl/tipi_pkg.sv
// tipi_pkg: shared FSM states and Pi pin encodings for the TIPI shift port
package tipi_pkg;
  typedef enum logic [1:0] {IDLE, TX, RX} state_t;
  localparam logic RT_READ  = 1'b0;
  localparam logic RT_WRITE = 1'b1;
  localparam logic CD_DATA  = 1'b0;
  localparam logic CD_CTRL  = 1'b1;
endpackage

// File: rtl/tipi_sync_edge.sv
// tipi_sync_edge: multi-flop synchroniser; low E bits get a registered rise pulse, the rest are levels
module tipi_sync_edge #(
  parameter int STAGES = 2,
  parameter int W      = 1,
  parameter int E      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     din,
  output logic [W-E-1:0]   level,
  output logic [E-1:0]     rise
);
  logic [STAGES-1:0][W-1:0] sync;
  logic [E-1:0]             prev;
  // shift pins through the synchroniser, then register a one-cycle rise pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= '0;
      rise <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1][E-1:0];
      rise <= sync[STAGES-1][E-1:0] & ~prev;
    end
  end
  assign level = sync[STAGES-1][W-1:E];
endmodule

// File: rtl/tipi_pi_shift_port.sv
// tipi_pi_shift_port: Pi-side serial port shifting TD/TC out and RD/RC in
module tipi_pi_shift_port
  import tipi_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RD_RESET    = '0,
  parameter logic [WIDTH-1:0] RC_RESET    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r_clk,
  input  logic             r_le,
  input  logic             r_rt,
  input  logic             r_cd,
  input  logic             r_din,
  output logic             r_dout,
  input  logic [WIDTH-1:0] td_in,
  input  logic [WIDTH-1:0] tc_in,
  output logic [WIDTH-1:0] rd_out,
  output logic [WIDTH-1:0] rc_out,
  output logic             rd_strobe,
  output logic             rc_strobe,
  output logic             frame_err
);
  localparam logic [3:0] FULL = 4'(WIDTH);
  localparam logic [3:0] LAST = 4'(WIDTH - 1);
  logic             clk_rise, le_rise, rt, cd, din;
  logic [WIDTH-1:0] sreg, sel;
  logic [3:0]       cnt;
  logic             ovr, ld, sh, commit, err;
  state_t           state, state_n;
  tipi_sync_edge #(.STAGES(SYNC_STAGES), .W(5), .E(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({r_din, r_cd, r_rt, r_le, r_clk}),
    .level ({din, cd, rt}),
    .rise  ({le_rise, clk_rise})
  );
  assign sel = (cd == CD_CTRL) ? tc_in : td_in;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state; le_rise always wins over a coincident clk_rise
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = le_rise ? ((rt == RT_WRITE) ? IDLE : TX)
                       : (clk_rise && rt == RT_WRITE) ? RX : IDLE;
      TX:      state_n = le_rise ? TX : (clk_rise && cnt == LAST) ? IDLE : TX;
      RX:      state_n = le_rise ? IDLE : RX;
      default: state_n = IDLE;
    endcase
  end
  // frame actions decoded from state and synchronised pin events
  always_comb begin
    ld     = le_rise && (state == TX || (state == IDLE && rt == RT_READ));
    sh     = clk_rise && !le_rise && (state != IDLE || rt == RT_WRITE);
    commit = le_rise && state == RX && cnt == FULL && !ovr;
    err    = le_rise && ((state == IDLE && rt == RT_WRITE) || (state == RX && !(cnt == FULL && !ovr)));
  end
  // shift register, bit counter, committed registers and one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg      <= '0;
      cnt       <= '0;
      ovr       <= 1'b0;
      r_dout    <= 1'b0;
      rd_out    <= RD_RESET;
      rc_out    <= RC_RESET;
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_strobe <= commit && cd == CD_DATA;
      rc_strobe <= commit && cd == CD_CTRL;
      frame_err <= err;
      if (commit && cd == CD_DATA) rd_out <= sreg;
      if (commit && cd == CD_CTRL) rc_out <= sreg;
      if (ld) begin
        sreg   <= sel;
        cnt    <= '0;
        r_dout <= sel[WIDTH-1];
      end else if (sh) begin
        sreg <= (state == TX) ? sreg << 1 : {sreg[WIDTH-2:0], din};
        cnt  <= (state == IDLE) ? 4'd1 : (cnt == FULL) ? cnt : cnt + 4'd1;
        ovr  <= (state == IDLE) ? 1'b0 : ovr | (state == RX && cnt == FULL);
        if (state == TX) r_dout <= (cnt == LAST) ? 1'b0 : sreg[WIDTH-2];
      end
    end
  end
endmodule

// File: tb/tb_tipi_pi_shift_port.sv
// tb_tipi_pi_shift_port: randomized self-checking bench against a frame-level model
module tb_tipi_pi_shift_port;
  localparam int H = 5;
  logic       clk = 0, reset = 1;
  logic       r_clk = 0, r_le = 0, r_rt = 0, r_cd = 0, r_din = 0;
  logic       r_dout, rd_strobe, rc_strobe, frame_err;
  logic [7:0] td_in = 0, tc_in = 0, rd_out, rc_out;
  logic [7:0] rd_m = 0, rc_m = 0, rd_seen = 0, rc_seen = 0;
  int n_chk = 0, n_err = 0;
  int n_rd = 0, n_rc = 0, n_fe = 0, n_wide = 0;
  int exp_rd = 0, exp_rc = 0, exp_fe = 0;
  logic rd_q = 0, rc_q = 0, fe_q = 0;

  tipi_pi_shift_port dut (
    .clk(clk), .reset(reset), .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_cd(r_cd),
    .r_din(r_din), .r_dout(r_dout), .td_in(td_in), .tc_in(tc_in), .rd_out(rd_out),
    .rc_out(rc_out), .rd_strobe(rd_strobe), .rc_strobe(rc_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_strobe) begin n_rd++; rd_seen = rd_out; if (rd_q) n_wide++; end
      if (rc_strobe) begin n_rc++; rc_seen = rc_out; if (rc_q) n_wide++; end
      if (frame_err) begin n_fe++; if (fe_q) n_wide++; end
    end
    rd_q = rd_strobe;
    rc_q = rc_strobe;
    fe_q = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin_clk(input logic b);
    r_din = b;
    wait_n(H);
    r_clk = 1;
    wait_n(H);
    r_clk = 0;
  endtask

  task automatic pin_le();
    wait_n(H);
    r_le = 1;
    wait_n(H);
    r_le = 0;
    wait_n(H);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_rd_out"}, rd_out, rd_m);
    chk({tag, "_rc_out"}, rc_out, rc_m);
    chk({tag, "_n_rd"}, n_rd, exp_rd);
    chk({tag, "_n_rc"}, n_rc, exp_rc);
    chk({tag, "_n_fe"}, n_fe, exp_fe);
    chk({tag, "_wide"}, n_wide, 0);
  endtask

  task automatic write_frame(input logic cd, input int nbits, input logic [15:0] bits);
    r_rt = 1;
    r_cd = cd;
    for (int i = 0; i < nbits; i++) pin_clk(bits[nbits-1-i]);
    pin_le();
    if (nbits == 8) begin
      if (cd) begin rc_m = bits[7:0]; exp_rc++; chk("wr_rc_seen", rc_seen, rc_m); end
      else begin rd_m = bits[7:0]; exp_rd++; chk("wr_rd_seen", rd_seen, rd_m); end
    end else exp_fe++;
    chk_regs("wr");
  endtask

  task automatic read_frame(input logic cd, input logic [7:0] td, input logic [7:0] tc, input int pre);
    logic [7:0] v;
    r_rt = 0;
    r_cd = cd;
    td_in = td;
    tc_in = tc;
    if (pre > 0) begin
      v = cd ? tc : td;
      pin_le();
      chk("rd_pre_msb", r_dout, v[7]);
      for (int i = 1; i <= pre; i++) begin
        pin_clk(1'($urandom));
        chk("rd_pre_bit", r_dout, v[7-i]);
      end
      td_in = 8'($urandom);
      tc_in = 8'($urandom);
    end
    v = cd ? tc_in : td_in;
    pin_le();
    chk("rd_msb", r_dout, v[7]);
    for (int i = 1; i <= 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin td_in = 8'($urandom); tc_in = 8'($urandom); end
      pin_clk(1'($urandom));
      chk("rd_bit", r_dout, (i < 8) ? 32'(v[7-i]) : 32'd0);
    end
    chk_regs("rd");
  endtask

  initial begin
    logic [7:0] v;
    wait_n(3);
    reset = 0;
    wait_n(2);
    chk("rst_rd_out", rd_out, 8'h00);
    chk("rst_rc_out", rc_out, 8'h00);
    chk("rst_dout", r_dout, 0);
    chk("rst_pulses", {rd_strobe, rc_strobe, frame_err}, 0);

    write_frame(0, 8, 16'h00A5);
    read_frame(1, 8'h11, 8'h3C, 0);
    write_frame(0, 5, 16'h0015);
    write_frame(1, 9, 16'h01FF);
    write_frame(1, 8, 16'h005A);

    r_rt = 1;
    r_cd = 0;
    for (int i = 0; i < 4; i++) pin_clk(1'b1);
    wait_n(H);
    reset = 1;
    wait_n(1);
    reset = 0;
    rd_m = 8'h00;
    rc_m = 8'h00;
    wait_n(1);
    chk("mid_rst_rd", rd_out, 8'h00);
    chk("mid_rst_rc", rc_out, 8'h00);
    chk("mid_rst_dout", r_dout, 0);
    write_frame(0, 8, 16'h00FF);

    r_rt = 0;
    r_cd = 0;
    td_in = 8'h80;
    wait_n(H);
    r_le = 1;
    repeat (3) @(posedge clk);
    #1 chk("lat_before", r_dout, 0);
    @(posedge clk);
    #1 chk("lat_at", r_dout, 1);
    wait_n(H);
    r_le = 0;
    for (int i = 1; i <= 8; i++) begin
      pin_clk(1'b0);
      chk("lat_bit", r_dout, 0);
    end

    v = 8'($urandom);
    r_rt = 1;
    r_cd = 0;
    for (int i = 7; i >= 0; i--) pin_clk(v[i]);
    r_din = ~v[0];
    wait_n(H);
    r_clk = 1;
    r_le = 1;
    wait_n(H);
    r_clk = 0;
    r_le = 0;
    wait_n(H);
    rd_m = v;
    exp_rd++;
    chk("simul_seen", rd_seen, v);
    chk_regs("simul");

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: write_frame(1'($urandom), 8, 16'($urandom));
        1: write_frame(1'($urandom), $urandom_range(0, 10), 16'($urandom));
        default: read_frame(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 7));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
